// File: rtl/key_scan_if.sv
// Key front-end bundle: raw active-low buttons in, press events,
// debounced levels and per-key repeat-FSM state out.
interface key_scan_if;
  logic [3:0] key_in;
  logic [3:0] key_flag;
  logic [3:0] key_held;
  logic [7:0] rp_state;

  modport master (output key_in, input key_flag, input key_held, input rp_state);
  modport slave  (input key_in, output key_flag, output key_held, output rp_state);
endinterface

// File: rtl/key_scan.sv
// Four independent key channels: 2-FF sync, debounce, press-edge flag and
// optional auto-repeat while the key stays held.
module key_scan #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HOLD_CYC     = 25_000_000,
  parameter int REPEAT_CYC   = 10_000_000,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  key_scan_if.slave  bus
);

  localparam int RP_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RP_W-1:0] HOLD_LAST = RP_W'(HOLD_CYC - 1);
  localparam logic [RP_W-1:0] RPT_LAST  = RP_W'(REPEAT_CYC - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_RPT  = 2'd2;

  logic [3:0]           s1_q, s1_d, s2_q, s2_d;
  logic [3:0]           stable_q, stable_d;
  logic [3:0][DB_W-1:0] cnt_db_q, cnt_db_d;
  logic [3:0]           held_q, held_d;
  logic [3:0]           held_prev_q, held_prev_d;
  logic [3:0]           flag_q, flag_d;
  logic [3:0][1:0]      st_q, st_d;
  logic [3:0][RP_W-1:0] cnt_rp_q, cnt_rp_d;
  logic [3:0]           press_w;

  // A press is the first cycle the registered debounced level reads 1.
  assign press_w = held_q & ~held_prev_q;

  always_comb begin
    s1_d        = bus.key_in;
    s2_d        = s1_q;
    stable_d    = stable_q;
    cnt_db_d    = cnt_db_q;
    held_d      = ~stable_q;
    held_prev_d = held_q;
    flag_d      = '0;
    st_d        = st_q;
    cnt_rp_d    = cnt_rp_q;

    for (int k = 0; k < 4; k++) begin
      if (s2_q[k] == stable_q[k]) begin
        cnt_db_d[k] = '0;
      end else if (cnt_db_q[k] == DB_LAST) begin
        stable_d[k] = s2_q[k];
        cnt_db_d[k] = '0;
      end else begin
        cnt_db_d[k] = cnt_db_q[k] + 1'b1;
      end

      if (press_w[k]) flag_d[k] = 1'b1;

      case (st_q[k])
        ST_IDLE: begin
          if (press_w[k]) begin
            st_d[k]     = ST_HOLD;
            cnt_rp_d[k] = '0;
          end
        end
        ST_HOLD: begin
          if (!held_q[k]) begin
            st_d[k]     = ST_IDLE;
            cnt_rp_d[k] = '0;
          end else if (cnt_rp_q[k] != HOLD_LAST) begin
            cnt_rp_d[k] = cnt_rp_q[k] + 1'b1;
          end else if (REPEAT_EN) begin
            flag_d[k]   = 1'b1;
            st_d[k]     = ST_RPT;
            cnt_rp_d[k] = '0;
          end
          // Without repeat the counter parks at HOLD_LAST until release.
        end
        ST_RPT: begin
          if (!held_q[k]) begin
            st_d[k]     = ST_IDLE;
            cnt_rp_d[k] = '0;
          end else if (cnt_rp_q[k] == RPT_LAST) begin
            flag_d[k]   = 1'b1;
            cnt_rp_d[k] = '0;
          end else begin
            cnt_rp_d[k] = cnt_rp_q[k] + 1'b1;
          end
        end
        default: begin
          st_d[k]     = ST_IDLE;
          cnt_rp_d[k] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= 4'hF;
      s2_q        <= 4'hF;
      stable_q    <= 4'hF;
      cnt_db_q    <= '0;
      held_q      <= '0;
      held_prev_q <= '0;
      flag_q      <= '0;
      st_q        <= {4{ST_IDLE}};
      cnt_rp_q    <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      stable_q    <= stable_d;
      cnt_db_q    <= cnt_db_d;
      held_q      <= held_d;
      held_prev_q <= held_prev_d;
      flag_q      <= flag_d;
      st_q        <= st_d;
      cnt_rp_q    <= cnt_rp_d;
    end
  end

  assign bus.key_flag = flag_q;
  assign bus.key_held = held_q;
  assign bus.rp_state = st_q;

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: one repeat-enabled and one repeat-disabled instance
// share the same key stimulus and are checked against hand-computed tables.
module tb_key_scan;

  localparam int DB  = 4;
  localparam int HLD = 20;
  localparam int RPT = 8;

  typedef struct {
    logic [3:0] key_in;
    logic [3:0] exp_flag_a;
    logic [3:0] exp_flag_b;
    logic [3:0] exp_held;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_drv = 4'hF;

  int n_total = 0;
  int n_pass  = 0;

  vec_t vq[$];

  key_scan_if ifa ();
  key_scan_if ifb ();

  assign ifa.key_in = key_drv;
  assign ifb.key_in = key_drv;

  key_scan #(.DEBOUNCE_CYC(DB), .HOLD_CYC(HLD), .REPEAT_CYC(RPT), .REPEAT_EN(1'b1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  key_scan #(.DEBOUNCE_CYC(DB), .HOLD_CYC(HLD), .REPEAT_CYC(RPT), .REPEAT_EN(1'b0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // table builders
  task automatic add_cycles(input logic [3:0] key, input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.key_in     = key;
      v.exp_flag_a = '0;
      v.exp_flag_b = '0;
      v.exp_held   = '0;
      vq.push_back(v);
    end
  endtask

  task automatic mark_flag(input int base, input int t, input int k, input bit a, input bit b);
    vec_t v;
    v = vq[base + t];
    if (a) v.exp_flag_a[k] = 1'b1;
    if (b) v.exp_flag_b[k] = 1'b1;
    vq[base + t] = v;
  endtask

  task automatic mark_held(input int base, input int t0, input int t1, input int k);
    vec_t v;
    for (int t = t0; t <= t1; t++) begin
      v = vq[base + t];
      v.exp_held[k] = 1'b1;
      vq[base + t] = v;
    end
  endtask

  initial begin
    int base;
    int first_a, first_b, cnt_a, cnt_b;
    int rpt_t[6];
    vec_t v;

    rpt_t = '{7, 27, 35, 43, 51, 59};

    // Clean press of key 0 for 12 cycles.
    base = vq.size();
    add_cycles(4'hE, 12);
    add_cycles(4'hF, 12);
    mark_flag(base, 7, 0, 1'b1, 1'b1);
    mark_held(base, 6, 17, 0);

    // Bounce on key 1: 3 low / 2 high, five times.
    for (int r = 0; r < 5; r++) begin
      add_cycles(4'hD, 3);
      add_cycles(4'hF, 2);
    end
    add_cycles(4'hF, 8);

    // Long hold of key 2 for 60 cycles.
    base = vq.size();
    add_cycles(4'hB, 60);
    add_cycles(4'hF, 14);
    foreach (rpt_t[i]) mark_flag(base, rpt_t[i], 2, 1'b1, 1'b0);
    mark_flag(base, 7, 2, 1'b0, 1'b1);
    mark_held(base, 6, 65, 2);

    // Keys 0 and 3 together.
    base = vq.size();
    add_cycles(4'b0110, 12);
    add_cycles(4'hF, 12);
    mark_flag(base, 7, 0, 1'b1, 1'b1);
    mark_flag(base, 7, 3, 1'b1, 1'b1);
    mark_held(base, 6, 17, 0);
    mark_held(base, 6, 17, 3);

    // Reset with keys released.
    rst = 1'b1;
    key_drv = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_flag_a", i, ifa.key_flag, 4'h0);
      check("rst_held_a", i, ifa.key_held, 4'h0);
      check("rst_flag_b", i, ifb.key_flag, 4'h0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("idle_flag_a", i, ifa.key_flag, 4'h0);
      check("idle_held_a", i, ifa.key_held, 4'h0);
    end

    // Table-driven run.
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      key_drv = v.key_in;
      step();
      check("vec_flag_a", i, ifa.key_flag, v.exp_flag_a);
      check("vec_flag_b", i, ifb.key_flag, v.exp_flag_b);
      check("vec_held_a", i, ifa.key_held, v.exp_held);
      check("vec_held_b", i, ifb.key_held, v.exp_held);
    end

    // Reset pulse mid-debounce with key 0 kept low.
    key_drv = 4'hE;
    for (int t = 0; t < 4; t++) begin
      if (t == 3) rst = 1'b1;
      step();
      check("pre_rst_flag_a", t, ifa.key_flag, 4'h0);
      check("pre_rst_flag_b", t, ifb.key_flag, 4'h0);
    end
    rst = 1'b0;
    first_a = -1;
    first_b = -1;
    cnt_a   = 0;
    cnt_b   = 0;
    for (int t = 0; t < 20; t++) begin
      step();
      if (ifa.key_flag[0]) begin
        cnt_a++;
        if (first_a < 0) first_a = t;
      end
      if (ifb.key_flag[0]) begin
        cnt_b++;
        if (first_b < 0) first_b = t;
      end
    end
    check("post_rst_first_a", 0, first_a, 7);
    check("post_rst_count_a", 0, cnt_a, 1);
    check("post_rst_first_b", 0, first_b, 7);
    check("post_rst_count_b", 0, cnt_b, 1);

    key_drv = 4'hF;
    for (int t = 0; t < 10; t++) step();
    check("final_held_a", 0, ifa.key_held, 4'h0);
    check("final_flag_a", 0, ifa.key_flag, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
